// File: rtl/dap_cmd_pkg.sv
// ----------------------------------------------------------------------------
// dap_cmd_pkg: command IDs, slot indices and FSM encoding for dap_cmd_dispatcher
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dap_cmd_pkg;

  localparam int CMD_SLOT_NUM = 8;
  localparam logic [7:0] DAP_ID_ERROR = 8'hFF;

  localparam logic [7:0] ID_INFO           = 8'h00;
  localparam logic [7:0] ID_HOST_STATUS    = 8'h01;
  localparam logic [7:0] ID_SWJ_PINS       = 8'h10;
  localparam logic [7:0] ID_SWJ_CLOCK      = 8'h11;
  localparam logic [7:0] ID_SWJ_SEQUENCE   = 8'h12;
  localparam logic [7:0] ID_SWD_SEQUENCE   = 8'h1D;
  localparam logic [7:0] ID_TRANSFER       = 8'h05;
  localparam logic [7:0] ID_TRANSFER_BLOCK = 8'h06;

  localparam logic [2:0] SLOT_INFO           = 3'd0;
  localparam logic [2:0] SLOT_HOST_STATUS    = 3'd1;
  localparam logic [2:0] SLOT_SWJ_PINS       = 3'd2;
  localparam logic [2:0] SLOT_SWJ_CLOCK      = 3'd3;
  localparam logic [2:0] SLOT_SWJ_SEQUENCE   = 3'd4;
  localparam logic [2:0] SLOT_SWD_SEQUENCE   = 3'd5;
  localparam logic [2:0] SLOT_TRANSFER       = 3'd6;
  localparam logic [2:0] SLOT_TRANSFER_BLOCK = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [CMD_SLOT_NUM-1:0] slot_onehot(input logic [2:0] slot);
    slot_onehot = '0;
    slot_onehot[slot] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dap_cmd_decode.sv
// ----------------------------------------------------------------------------
// dap_cmd_decode: combinational command ID to {known, slot} lookup
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dap_cmd_decode
  import dap_cmd_pkg::*;
(
  input  logic [7:0] cmd_id,
  output logic       known,
  output logic [2:0] slot
);

  always_comb begin
    known = 1'b1;
    slot  = SLOT_INFO;
    case (cmd_id)
      ID_INFO:           slot = SLOT_INFO;
      ID_HOST_STATUS:    slot = SLOT_HOST_STATUS;
      ID_SWJ_PINS:       slot = SLOT_SWJ_PINS;
      ID_SWJ_CLOCK:      slot = SLOT_SWJ_CLOCK;
      ID_SWJ_SEQUENCE:   slot = SLOT_SWJ_SEQUENCE;
      ID_SWD_SEQUENCE:   slot = SLOT_SWD_SEQUENCE;
      ID_TRANSFER:       slot = SLOT_TRANSFER;
      ID_TRANSFER_BLOCK: slot = SLOT_TRANSFER_BLOCK;
      default:           known = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dap_cmd_dispatcher.sv
// ----------------------------------------------------------------------------
// dap_cmd_dispatcher: routes a CMSIS-DAP command byte to one of eight engines;
// optional RUN watchdog enabled by DAP_CMD_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dap_cmd_dispatcher
  import dap_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int          LEN_W          = 10
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          dap_in_tvalid,
  input  logic [7:0]                    dap_in_tdata,
  output logic                          dap_in_tready,
  input  logic [CMD_SLOT_NUM-1:0]       cmd_tready,
  output logic [CMD_SLOT_NUM-1:0]       start,
  input  logic [CMD_SLOT_NUM-1:0]       done,
  input  logic [CMD_SLOT_NUM*LEN_W-1:0] eng_packet_len,
  output logic [LEN_W-1:0]              ram_write_addr,
  output logic [7:0]                    ram_write_data,
  output logic                          ram_write_en,
  output logic                          resp_valid,
  output logic [LEN_W-1:0]              resp_len,
  input  logic                          resp_ready,
  output logic                          busy,
  output logic                          timeout_flag
);

  state_t           state;
  logic [7:0]       cmd_id;
  logic [2:0]       slot;
  logic             idle_rdy;
  logic [7:0]       dec_in;
  logic             dec_known;
  logic [2:0]       dec_slot;
  logic [LEN_W-1:0] eng_len [CMD_SLOT_NUM];

  // One decoder serves both the accept cycle (live byte) and HDR (latched ID).
  assign dec_in = (state == ST_IDLE) ? dap_in_tdata : cmd_id;

  dap_cmd_decode u_decode (
    .cmd_id (dec_in),
    .known  (dec_known),
    .slot   (dec_slot)
  );

  for (genvar i = 0; i < CMD_SLOT_NUM; i++) begin : g_len
    assign eng_len[i] = eng_packet_len[i*LEN_W +: LEN_W];
  end

  // idle_rdy is held low on the first IDLE cycle after reset so ready rises one edge later.
  assign dap_in_tready = idle_rdy | ((state == ST_RUN) & cmd_tready[slot]);

`ifdef DAP_CMD_TIMEOUT_EN
  logic [31:0] wd_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_flag       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      cmd_id         <= '0;
      slot           <= '0;
      idle_rdy       <= 1'b0;
      start          <= '0;
      ram_write_en   <= 1'b0;
      ram_write_addr <= '0;
      ram_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_len       <= '0;
      busy           <= 1'b0;
`ifdef DAP_CMD_TIMEOUT_EN
      wd_cnt         <= '0;
      timeout_flag   <= 1'b0;
`endif
    end else begin
      ram_write_en <= 1'b0;
`ifdef DAP_CMD_TIMEOUT_EN
      timeout_flag <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (idle_rdy && dap_in_tvalid) begin
            cmd_id         <= dap_in_tdata;
            slot           <= dec_slot;
            ram_write_en   <= 1'b1;
            ram_write_addr <= '0;
            ram_write_data <= dec_known ? dap_in_tdata : DAP_ID_ERROR;
            idle_rdy       <= 1'b0;
            busy           <= 1'b1;
            state          <= ST_HDR;
          end else begin
            idle_rdy <= 1'b1;
          end
        end
        ST_HDR: begin
          if (dec_known) begin
            start <= slot_onehot(slot);
            state <= ST_RUN;
`ifdef DAP_CMD_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end else begin
            resp_len   <= LEN_W'(1);
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RUN: begin
          if (done[slot]) begin
            start      <= '0;
            resp_len   <= eng_len[slot];
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
`ifdef DAP_CMD_TIMEOUT_EN
          // done is checked first so it wins a tie with expiry.
          else if (wd_cnt + 32'd1 == TIMEOUT_CYCLES) begin
            start          <= '0;
            ram_write_en   <= 1'b1;
            ram_write_addr <= LEN_W'(1);
            ram_write_data <= DAP_ID_ERROR;
            resp_len       <= LEN_W'(2);
            resp_valid     <= 1'b1;
            timeout_flag   <= 1'b1;
            wd_cnt         <= wd_cnt + 32'd1;
            state          <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            idle_rdy   <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dap_cmd_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_dap_cmd_dispatcher: randomized scoreboard bench for dap_cmd_dispatcher
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dap_cmd_dispatcher;

  localparam int LEN_W = 10;
  localparam int TB_TO = 16;
`ifdef DAP_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 dap_in_tvalid = 1'b0;
  logic [7:0]           dap_in_tdata = '0;
  logic                 dap_in_tready;
  logic [7:0]           cmd_tready = '0;
  logic [7:0]           start;
  logic [7:0]           done = '0;
  logic [8*LEN_W-1:0]   eng_packet_len = '0;
  logic [LEN_W-1:0]     ram_write_addr;
  logic [7:0]           ram_write_data;
  logic                 ram_write_en;
  logic                 resp_valid;
  logic [LEN_W-1:0]     resp_len;
  logic                 resp_ready = 1'b0;
  logic                 busy;
  logic                 timeout_flag;

  always #5 clk = ~clk;

  dap_cmd_dispatcher #(.TIMEOUT_CYCLES(TB_TO), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .dap_in_tvalid  (dap_in_tvalid),
    .dap_in_tdata   (dap_in_tdata),
    .dap_in_tready  (dap_in_tready),
    .cmd_tready     (cmd_tready),
    .start          (start),
    .done           (done),
    .eng_packet_len (eng_packet_len),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_write_en   (ram_write_en),
    .resp_valid     (resp_valid),
    .resp_len       (resp_len),
    .resp_ready     (resp_ready),
    .busy           (busy),
    .timeout_flag   (timeout_flag)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference tables and scoreboard queues.
  logic [7:0]             known_ids [8] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h1D, 8'h05, 8'h06};
  int                     slot_of [logic [7:0]];
  logic [LEN_W+7:0]       hdr_q   [$];
  logic [7:0]             start_q [$];
  logic [LEN_W-1:0]       resp_q  [$];
  bit                     to_q    [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  int               acc_cnt = -1;
  logic [7:0]       prev_start = '0;
  logic             prev_rv = 1'b0;
  logic [LEN_W-1:0] held_len = '0;
  int               cur_slot = 0;
  logic [7:0]       es;

  always @(negedge clk) begin
    if (!resetn) begin
      acc_cnt    = -1;
      prev_start = '0;
      prev_rv    = 1'b0;
    end else begin
      if (acc_cnt >= 0) acc_cnt++;
      if (ram_write_en) begin
        if (hdr_q.size() == 0) check("hdr_unexpected", ram_write_en, 1'b0);
        else check("hdr_write", {ram_write_addr, ram_write_data}, hdr_q.pop_front());
      end
      if (start != 0 && prev_start == 0) begin
        if (start_q.size() == 0) check("start_unexpected", start, 8'h00);
        else begin
          es = start_q.pop_front();
          check("start_value", start, es);
          check("start_latency", acc_cnt, 2);
          for (int i = 0; i < 8; i++) if (es[i]) cur_slot = i;
        end
      end
      if (start != 0) begin
        check("start_onehot", $onehot(start), 1'b1);
        check("start_only_in_run", {busy, resp_valid}, 2'b10);
        check("tready_mirror", dap_in_tready, cmd_tready[cur_slot]);
      end
      if (timeout_flag) begin
        if (to_q.size() == 0) check("timeout_unexpected", timeout_flag, 1'b0);
        else check("timeout_flag", timeout_flag, to_q.pop_front());
      end
      if (resp_valid) begin
        if (prev_rv) begin
          check("resp_len_stable", resp_len, held_len);
          check("tready_low_in_resp", dap_in_tready, 1'b0);
        end
        held_len = resp_len;
        if (resp_ready) begin
          if (resp_q.size() == 0) check("resp_unexpected", resp_valid, 1'b0);
          else check("resp_len", resp_len, resp_q.pop_front());
        end
      end
      if (dap_in_tvalid && dap_in_tready && !busy) acc_cnt = 0;
      prev_start = start;
      prev_rv    = resp_valid;
    end
  end

  task automatic do_cmd(input logic [7:0] id, input int delay, input logic [LEN_W-1:0] len,
                        input int hold);
    bit         known;
    bit         tmo;
    int         sl;
    int         n;
    logic [7:0] oh;
    known = slot_of.exists(id);
    sl    = known ? slot_of[id] : 0;
    oh    = 8'h01 << sl;
    tmo   = TO_EN && known && (delay >= TB_TO);
    for (int i = 0; i < 8; i++) eng_packet_len[i*LEN_W +: LEN_W] = LEN_W'($urandom);
    eng_packet_len[sl*LEN_W +: LEN_W] = len;
    hdr_q.push_back({LEN_W'(0), known ? id : 8'hFF});
    if (known) start_q.push_back(oh);
    if (tmo) begin
      hdr_q.push_back({LEN_W'(1), 8'hFF});
      to_q.push_back(1'b1);
      resp_q.push_back(LEN_W'(2));
    end else begin
      resp_q.push_back(known ? len : LEN_W'(1));
    end

    dap_in_tvalid = 1'b1;
    dap_in_tdata  = id;
    n = 0;
    do begin tick(); n++; end while (!busy && n < 50);
    dap_in_tvalid = 1'b0;
    check("accepted", busy, 1'b1);

    if (known) begin
      n = 0;
      while (!start[sl] && n < 10) begin tick(); n++; end
      if (start[sl]) begin
        for (int i = 0; i < delay; i++) begin
          done          = 8'($urandom) & ~oh;
          cmd_tready    = 8'($urandom);
          dap_in_tvalid = 1'($urandom);
          tick();
          if (!start[sl]) break;
        end
        dap_in_tvalid = 1'b0;
        if (start[sl]) begin
          done = oh | (8'($urandom) & ~oh);
          tick();
        end
        done = '0;
      end
    end

    n = 0;
    while (!resp_valid && n < 10) begin tick(); n++; end
    check("resp_arrives", resp_valid, 1'b1);
    repeat (hold) tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic reset_mid_run(input logic [7:0] id);
    int n;
    int sl;
    sl = slot_of[id];
    hdr_q.push_back({LEN_W'(0), id});
    start_q.push_back(8'h01 << sl);
    dap_in_tvalid = 1'b1;
    dap_in_tdata  = id;
    n = 0;
    do begin tick(); n++; end while (!busy && n < 50);
    dap_in_tvalid = 1'b0;
    n = 0;
    while (!start[sl] && n < 10) begin tick(); n++; end
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    check("abort_start", start, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_resp_valid", resp_valid, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_resp", resp_valid, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rid;
    for (int i = 0; i < 8; i++) slot_of[known_ids[i]] = i;

    repeat (3) tick();
    check("rst_start", start, 8'h00);
    check("rst_ram_we", ram_write_en, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout_flag, 1'b0);
    check("rst_tready", dap_in_tready, 1'b0);
    check("rst_resp_len", resp_len, 0);
    check("rst_ram_addr_data", {ram_write_addr, ram_write_data}, 0);
    resetn = 1'b1;
    #1;
    check("tready_before_edge", dap_in_tready, 1'b0);
    tick();
    check("tready_after_release", dap_in_tready, 1'b1);

    do_cmd(8'h12, 20, LEN_W'(5), 0);
    do_cmd(8'h7E, 0, LEN_W'(0), 10);
    do_cmd(8'h06, 8, LEN_W'(300), 3);
    do_cmd(8'h01, 0, LEN_W'(7), 1);
    reset_mid_run(8'h11);
    do_cmd(8'h11, 4, LEN_W'(1023), 2);
    do_cmd(8'h05, TB_TO - 1, LEN_W'(9), 0);
    do_cmd(8'h05, TB_TO + 9, LEN_W'(9), 0);

    for (int k = 0; k < 40; k++) begin
      rid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : known_ids[$urandom_range(0, 7)];
      do_cmd(rid, $urandom_range(0, 20), LEN_W'($urandom), $urandom_range(0, 10));
    end

    repeat (5) tick();
    check("queues_drained", hdr_q.size() + start_q.size() + resp_q.size() + to_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dap_cmd_dispatcher.md
DAP_CMD_DISPATCHER -- requirements
Module: dap_cmd_dispatcher

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535: maximum clk cycles spent waiting for done (used only with DAP_CMD_TIMEOUT_EN).
REQ-002 Parameter LEN_W, default 10: width of the packet length.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 dap_in_tvalid  in  1  request stream byte valid.
REQ-006 dap_in_tdata  in  8  request stream byte.
REQ-007 dap_in_tready  out  1  request byte consumed.
REQ-008 cmd_tready  in  8  per-engine stream ready, one bit per slot.
REQ-009 start  out  8  one-hot engine start, one bit per slot.
REQ-010 done  in  8  per-engine done, one bit per slot.
REQ-011 eng_packet_len  in  8*LEN_W  per-slot response length, flattened with slot 0 in the LSBs.
REQ-012 ram_write_addr / ram_write_data / ram_write_en  out  LEN_W / 8 / 1  response RAM header writes.
REQ-013 resp_valid  out  1, resp_len  out  LEN_W, resp_ready  in  1: response handoff.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 timeout_flag  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-016 States: IDLE, HDR, RUN, RESP. No other states exist.
REQ-017 IDLE: dap_in_tready is 1. When dap_in_tvalid is 1, the block latches the byte as cmd_id and moves to HDR.
REQ-018 HDR: lasts one cycle. Writes addr 0 = cmd_id with ram_write_en = 1. dap_in_tready is 0.
REQ-019 HDR, known ID: the block sets start[slot] = 1 on the next edge and moves to RUN.
REQ-020 HDR, unknown ID: the block writes addr 0 = 0xFF instead, sets resp_len = 1, and moves to RESP. start stays 0.
REQ-021 Slot map: 0x00→0, 0x01→1, 0x10→2, 0x11→3, 0x12→4, 0x1D→5, 0x05→6, 0x06→7.
REQ-022 RUN: start[slot] stays 1 until done[slot] is sampled high, then clears on the same edge. The block latches resp_len = eng_packet_len[slot] and moves to RESP.
REQ-023 RUN: dap_in_tready = dap_in_tvalid-independent cmd_tready[slot]. All other cmd_tready bits are ignored.
REQ-024 done bits of non-selected slots are ignored in every state.
REQ-025 start is always one-hot or zero. It is never asserted outside RUN.
REQ-026 RESP: resp_valid = 1 and resp_len is held stable. On resp_valid & resp_ready the block returns to IDLE; the next byte is accepted no earlier than the following cycle.
REQ-027 Minimum latency from ID byte accept to start[slot] high: 2 edges.
REQ-028 If done[slot] is already high on the first RUN cycle, the block still exits on that cycle, so start is high for exactly one cycle.
REQ-029 resp_len is LEN_W bits wide and passes through without arithmetic.

Reset
REQ-030 With resetn low at an edge: state = IDLE; start, ram_write_en, resp_valid, busy, timeout_flag, dap_in_tready all 0; resp_len, ram_write_addr, ram_write_data, cmd_id, watchdog counter all 0.
REQ-031 dap_in_tready rises on the first edge after resetn returns high.
REQ-032 Reset asserted mid-RUN drops start on that edge. No response is produced for the aborted command.

Configuration
REQ-033 Macro DAP_CMD_TIMEOUT_EN.
- Defined: a 32-bit counter clears on RUN entry and increments each RUN cycle. When it reaches TIMEOUT_CYCLES, start clears, the block writes addr 1 = 0xFF, resp_len = 2, timeout_flag pulses for one cycle, and the block moves to RESP.
- If done arrives on the same edge as expiry, done wins.
- Undefined: no counter; RUN waits indefinitely; timeout_flag is tied to 0.

Structure
REQ-034 Shared package dap_cmd_pkg: command ID constants, slot-index constants, CMD_SLOT_NUM = 8, DAP_ID_ERROR = 0xFF, state encoding.
REQ-035 One sub-module, dap_cmd_decode: combinational cmd_id → {known, slot[2:0]}.

Verification
REQ-036 Byte 0x12 → HDR writes addr0 = 0x12; start = 0x10 two edges after accept; done[4] after 20 cycles with len 5 → start = 0, resp_len = 5, resp_valid = 1.
REQ-037 Byte 0x7E → addr0 = 0xFF; start never asserted; resp_len = 1.
REQ-038 ID 0x06 in RUN, cmd_tready[7] toggled with tvalid held 1 → dap_in_tready mirrors cmd_tready[7] exactly; done[5] pulsed → ignored.
REQ-039 resetn low for 1 cycle mid-RUN → start = 0, busy = 0, resp_valid stays 0; next ID byte is dispatched normally.
REQ-040 With DAP_CMD_TIMEOUT_EN and TIMEOUT_CYCLES = 16, ID 0x05 and no done → after 16 RUN cycles: timeout_flag pulse, addr1 = 0xFF, resp_len = 2.
REQ-041 resp_ready held 0 for 10 cycles → resp_valid and resp_len stable, dap_in_tready = 0 throughout.
